mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory request channel between an
// instruction-fetch port and a data load/store port. One transaction is in
// flight at a time, with a per-transaction timeout that aborts with err.
//
// state  | meaning
// IDLE   | no transaction in flight, arbitrating pending ports
// BUSY_I | fetch transaction presented on the memory channel
// BUSY_D | data transaction presented on the memory channel
module mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read_en,
    input  logic        d_write_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_d;
    logic [7:0]  r_cnt;
    logic        r_if_ready;
    logic        r_d_ready;
    logic        r_err;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_pend_i;
    logic        w_pend_d;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_ack;
    logic        w_tout;

    // A port whose ready pulse is showing this cycle is already served.
    assign w_pend_i = if_req & ~r_if_ready;
    assign w_pend_d = (d_read_en | d_write_en) & ~r_d_ready;

    // Next-state and grant/completion decisions
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_ack       = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_i && w_pend_d) begin
                    if (PRIORITY_MODE == 0 || !r_last_d) w_grant_d = 1'b1;
                    else                                 w_grant_i = 1'b1;
                end else if (w_pend_d) begin
                    w_grant_d = 1'b1;
                end else if (w_pend_i) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d)      w_state_nxt = BUSY_D;
                else if (w_grant_i) w_state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                // An ack on the timeout edge is a normal completion.
                if (mem_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == TOUT_LAST) begin
                    w_tout      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Memory channel, timeout counter and port response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_last_d    <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
            if (w_grant_i) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= if_addr;
                r_last_d   <= 1'b0;
                r_cnt      <= '0;
            end
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_write_en;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_last_d    <= 1'b1;
                r_cnt       <= '0;
            end
            if (r_state != IDLE && !w_ack && !w_tout) r_cnt <= r_cnt + 8'd1;
            if (w_ack || w_tout) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_err     <= w_tout;
                if (r_state == BUSY_I) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= w_ack ? mem_rdata : 32'd0;
                end else begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= (w_ack && !r_mem_we) ? mem_rdata : 32'd0;
                end
            end
        end
    end

    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = (if_req & ~r_if_ready) | ((d_read_en | d_write_en) & ~r_d_ready);

endmodule
